spike_event_fifo: RTL and testbench

Parametrised successor to the fixed inter-layer spike FIFOs between the spike code converter, conv and fc stages. It buffers WIDTH-bit synapse-index events and tags each stored word with a timestep-end marker. It provides programmable almost-full and almost-empty thresholds, an occupancy count, a complete-timestep counter, sticky overflow and underflow flags, synchronous flush, and a selectable first-word-fall-through read mode. One instance sits between each pair of SNN layers.

---
 rtl/spike_event_fifo.sv | 93 +++++++++
 tb/tb_spike_event_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: inter-layer spike event FIFO with timestep tagging, thresholds, sticky error flags and optional FWFT read
//   clk, rst (async, active-high), flush (sync clear)
//   wr_en / wr_data / wr_ts_end : event write with timestep-end tag
//   rd_en / rd_data / rd_ts_end : event read (registered or first-word-fall-through)
//   fifo_full, fifo_empty, almost_full, almost_empty, count : occupancy status
//   ts_ready : at least one complete timestep buffered
//   overflow, underflow, clr_flags : sticky error flags and their clear
module spike_event_fifo #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_ts_end,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_ts_end,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ts_ready,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_flags
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    if (DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_chk
        $error("spike_event_fifo: DEPTH must equal 2**ADDR_WIDTH");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_thresh_chk
        $error("spike_event_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [WIDTH:0]          mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]     cnt, ts_cnt;
    logic [WIDTH:0]          rd_q, head;
    logic                    wr_acc, rd_acc, ovf_set, unf_set;

    assign fifo_full    = cnt == DEPTH_C;
    assign fifo_empty   = cnt == '0;
    assign almost_full  = cnt >= AF_C;
    assign almost_empty = cnt <= AE_C;
    assign count        = cnt;
    assign ts_ready     = ts_cnt != '0;

    assign wr_acc  = wr_en && !fifo_full && !flush;
    assign rd_acc  = rd_en && !fifo_empty && !flush;
    assign ovf_set = wr_en && fifo_full && !flush;
    assign unf_set = rd_en && fifo_empty && !flush;
    assign head    = mem[rd_ptr];

    // FWFT shows the head word directly; zero while empty keeps the reset view clean
    assign {rd_ts_end, rd_data} = (FWFT != 0) ? (fifo_empty ? '0 : head) : rd_q;

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= {wr_ts_end, wr_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ts_cnt    <= '0;
            rd_q      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= flush ? '0 : wr_ptr + ADDR_WIDTH'(wr_acc);
            rd_ptr    <= flush ? '0 : rd_ptr + ADDR_WIDTH'(rd_acc);
            cnt       <= flush ? '0 : cnt + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
            ts_cnt    <= flush ? '0 : ts_cnt + (ADDR_WIDTH + 1)'(wr_acc && wr_ts_end)
                                             - (ADDR_WIDTH + 1)'(rd_acc && head[WIDTH]);
            rd_q      <= rd_acc ? head : rd_q;
            // a set in the same cycle outranks the clear
            overflow  <= ovf_set || (overflow && !clr_flags);
            underflow <= unf_set || (underflow && !clr_flags);
        end
    end
endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo: directed plus randomized checks of both read modes against a queue model
module tb_spike_event_fifo;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, wr_en = 1'b0, wr_ts_end = 1'b0, rd_en = 1'b0, clr_flags = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_ts0, rd_ts1, full0, full1, empty0, empty1, af0, af1, ae0, ae1, tsr0, tsr1;
    logic        ovf0, ovf1, unf0, unf1;
    logic [10:0] cnt0, cnt1;

    int tests = 0, fails = 0;
    logic [16:0] q[$];
    logic [16:0] rd0 = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;

    always #5 clk = ~clk;

    spike_event_fifo #(.FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .wr_ts_end(wr_ts_end),
        .rd_en(rd_en), .rd_data(rd_data0), .rd_ts_end(rd_ts0), .fifo_full(full0), .fifo_empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0), .ts_ready(tsr0), .overflow(ovf0),
        .underflow(unf0), .clr_flags(clr_flags));

    spike_event_fifo #(.FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .wr_ts_end(wr_ts_end),
        .rd_en(rd_en), .rd_data(rd_data1), .rd_ts_end(rd_ts1), .fifo_full(full1), .fifo_empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1), .ts_ready(tsr1), .overflow(ovf1),
        .underflow(unf1), .clr_flags(clr_flags));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int tags_in_queue();
        int n = 0;
        foreach (q[i]) n += int'(q[i][16]);
        return n;
    endfunction

    task automatic check_all();
        int sz = q.size();
        chk("count", 32'(cnt0), 32'(sz));
        chk("fifo_full", 32'(full0), 32'(sz == 1024));
        chk("fifo_empty", 32'(empty0), 32'(sz == 0));
        chk("almost_full", 32'(af0), 32'(sz >= 1020));
        chk("almost_empty", 32'(ae0), 32'(sz <= 4));
        chk("ts_ready", 32'(tsr0), 32'(tags_in_queue() > 0));
        chk("overflow", 32'(ovf0), 32'(m_ovf));
        chk("underflow", 32'(unf0), 32'(m_unf));
        chk("rd_word_reg", {15'd0, rd_ts0, rd_data0}, {15'd0, rd0});
        chk("count_fwft", 32'(cnt1), 32'(sz));
        if (sz > 0) chk("rd_word_fwft", {15'd0, rd_ts1, rd_data1}, {15'd0, q[0]});
    endtask

    task automatic cyc(input logic w, input logic [15:0] d, input logic t, input logic r,
                       input logic f, input logic c);
        int  sz = q.size();
        logic wa, ra, os, us;
        wr_en = w; wr_data = d; wr_ts_end = t; rd_en = r; flush = f; clr_flags = c;
        wa = w && sz < 1024 && !f;
        ra = r && sz > 0 && !f;
        os = w && sz == 1024 && !f;
        us = r && sz == 0 && !f;
        @(posedge clk); #1;
        if (f) q.delete();
        else begin
            if (ra) rd0 = q.pop_front();
            if (wa) q.push_back({t, d});
        end
        m_ovf = os || (m_ovf && !c);
        m_unf = us || (m_unf && !c);
        wr_en = 0; rd_en = 0; flush = 0; clr_flags = 0; wr_ts_end = 0;
        check_all();
    endtask

    initial begin
        #1 check_all();
        #11 rst = 1'b0;
        check_all();
        // fill to full with an ascending ramp, then one rejected write
        for (int i = 0; i < 1024; i++) cyc(1, 16'(i), 0, 0, 0, 0);
        cyc(1, 16'hFFFF, 0, 0, 0, 0);
        chk("ovf_on_full", 32'(ovf0), 32'd1);
        // drain in order, then one read on empty
        for (int i = 0; i < 1024; i++) cyc(0, 0, 0, 1, 0, 0);
        chk("last_read", 32'(rd_data0), 32'h03FF);
        cyc(0, 0, 0, 1, 0, 0);
        chk("unf_on_empty", 32'(unf0), 32'd1);
        chk("rd_hold_empty", 32'(rd_data0), 32'h03FF);
        cyc(0, 0, 0, 0, 0, 1);
        // steady occupancy of 3 across pointer wrap
        for (int i = 0; i < 3; i++) cyc(1, 16'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) cyc(1, 16'($urandom), 1'($urandom), 1, 0, 0);
        chk("steady_count", 32'(cnt0), 32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        // timestep tagging
        cyc(1, 16'h000A, 0, 0, 0, 0);
        cyc(1, 16'h000B, 1, 0, 0, 0);
        cyc(1, 16'h000C, 0, 0, 0, 0);
        cyc(1, 16'h000D, 1, 0, 0, 0);
        chk("ts_ready_2", 32'(tsr0), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ts_end_B", 32'(rd_ts0), 32'd1);
        chk("ts_ready_1", 32'(tsr0), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ts_end_C", 32'(rd_ts0), 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ts_ready_0", 32'(tsr0), 32'd0);
        // fall-through presentation
        cyc(1, 16'h1234, 0, 0, 0, 0);
        chk("fwft_present", 32'(rd_data1), 32'h1234);
        cyc(0, 0, 0, 1, 0, 0);
        chk("fwft_empty", 32'(empty1), 32'd1);
        // flush wins over a write
        for (int i = 0; i < 10; i++) cyc(1, 16'($urandom), 1'($urandom), 0, 0, 0);
        cyc(1, 16'h5555, 0, 0, 1, 0);
        chk("flush_count", 32'(cnt0), 32'd0);
        chk("flush_no_ovf", 32'(ovf0), 32'd0);
        // set beats clear
        for (int i = 0; i < 1024; i++) cyc(1, 16'($urandom), 1'($urandom), 0, 0, 0);
        cyc(1, 16'h7777, 0, 0, 0, 1);
        chk("ovf_set_wins", 32'(ovf0), 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ovf_cleared", 32'(ovf0), 32'd0);
        cyc(0, 0, 0, 0, 1, 0);
        // randomized traffic: fill-biased then drain-biased
        for (int i = 0; i < 3000; i++) begin
            int wp = (i < 1500) ? 80 : 25;
            cyc(1'($urandom_range(0, 99) < wp), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 99) >= wp), 1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 49) == 0));
        end
        // asynchronous reset mid-burst
        for (int i = 0; i < 20; i++) cyc(1, 16'($urandom), 1'($urandom), 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        q.delete(); rd0 = '0; m_ovf = 0; m_unf = 0;
        check_all();
        chk("rst_fwft_data", {15'd0, rd_ts1, rd_data1}, 32'd0);
        @(negedge clk) rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
